// File: rtl/tile_input_ctrl.sv
// -----------------------------------------------------------------------------
// tile_input_ctrl
//
// Front-end for the tile-matching game. It synchronises and debounces the raw
// DE1 pushbuttons and slide switches. It turns key presses into single-cycle
// select1 / select2 / userquit pulses and tracks the session-active level
// inGameOn. A rising edge of the in-game FSM's gameOver flag ends the session.
//
// Optional feature (macro ONEHOT_GUARD_EN):
//   defined   : sw_error is high while two or more debounced switches are up.
//               It follows SW_db by one cycle. While it is high, select presses
//               are dropped.
//   undefined : sw_error is tied low and selects are never gated by SW.
//
// Ports:
//   CLOCK_50  in   1   system clock
//   clear     in   1   asynchronous active-low reset
//   KEY       in   4   raw pushbuttons, active-low
//                      [0]=quit, [1]=select1, [2]=select2, [3]=start
//   SW        in   10  raw slide switches
//   gameOver  in   1   level from the in-game FSM
//   select1   out  1   one-cycle pulse
//   select2   out  1   one-cycle pulse
//   userquit  out  1   one-cycle pulse
//   inGameOn  out  1   level, session active
//   SW_db     out  10  debounced switch vector
//   sw_error  out  1   more than one debounced switch up
// -----------------------------------------------------------------------------
module tile_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES    = 1000000,
  parameter int unsigned SW_DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       clear,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  input  logic       gameOver,
  output logic       select1,
  output logic       select2,
  output logic       userquit,
  output logic       inGameOn,
  output logic [9:0] SW_db,
  output logic       sw_error
);

  localparam int unsigned NUM_KEYS  = 4;
  localparam int unsigned NUM_SW    = 10;
  localparam int unsigned KEY_QUIT  = 0;
  localparam int unsigned KEY_SEL1  = 1;
  localparam int unsigned KEY_SEL2  = 2;
  localparam int unsigned KEY_START = 3;

  localparam int unsigned KEY_CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SW_CNT_W =
    (SW_DEBOUNCE_CYCLES > 1) ? $clog2(SW_DEBOUNCE_CYCLES) : 1;

  localparam logic [KEY_CNT_W-1:0] KEY_CNT_MAX = KEY_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW_CNT_W-1:0]  SW_CNT_MAX  = SW_CNT_W'(SW_DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } session_e;

  // ---------------------------------------------------------------------------
  // Key synchronisers and per-key debounce
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0]                key_meta_q;
  logic [NUM_KEYS-1:0]                key_sync_q;
  logic [NUM_KEYS-1:0]                key_stable_q;
  logic [NUM_KEYS-1:0]                key_stable_d_q;
  logic [NUM_KEYS-1:0][KEY_CNT_W-1:0] key_cnt_q;

  logic [NUM_KEYS-1:0]                key_stable_n;
  logic [NUM_KEYS-1:0][KEY_CNT_W-1:0] key_cnt_n;
  logic [NUM_KEYS-1:0]                key_fall_c;

  // The counter runs only while the synced key disagrees with the stable state.
  // Any agreement restarts it, so only an unbroken run flips the state.
  always_comb begin
    key_stable_n = key_stable_q;
    key_cnt_n    = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_sync_q[i] != key_stable_q[i]) begin
        if (key_cnt_q[i] == KEY_CNT_MAX) begin
          key_stable_n[i] = key_sync_q[i];
        end else begin
          key_cnt_n[i] = key_cnt_q[i] + KEY_CNT_W'(1);
        end
      end
    end
  end

  // Key pipeline: two-flop sync, debounced state, and a delayed copy of that state for edge detection.
  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      key_meta_q     <= '1;
      key_sync_q     <= '1;
      key_stable_q   <= '1;
      key_stable_d_q <= '1;
      key_cnt_q      <= '0;
    end else begin
      key_meta_q     <= KEY;
      key_sync_q     <= key_meta_q;
      key_stable_q   <= key_stable_n;
      key_stable_d_q <= key_stable_q;
      key_cnt_q      <= key_cnt_n;
    end
  end

  // Press = debounced 1->0 transition; release produces nothing.
  assign key_fall_c = key_stable_d_q & ~key_stable_q;

  // ---------------------------------------------------------------------------
  // Switch synchroniser and whole-vector debounce
  // ---------------------------------------------------------------------------
  logic [NUM_SW-1:0]   sw_meta_q;
  logic [NUM_SW-1:0]   sw_sync_q;
  logic [NUM_SW-1:0]   sw_cand_q;
  logic [SW_CNT_W-1:0] sw_cnt_q;

  logic [NUM_SW-1:0]   sw_cand_n;
  logic [SW_CNT_W-1:0] sw_cnt_n;
  logic [NUM_SW-1:0]   sw_db_n;

  // Any change anywhere in the vector reloads the candidate and restarts the count.
  // The counter saturates at its limit, so a settled candidate keeps being re-accepted.
  always_comb begin
    sw_cand_n = sw_cand_q;
    sw_cnt_n  = sw_cnt_q;
    sw_db_n   = SW_db;
    if (sw_sync_q != sw_cand_q) begin
      sw_cand_n = sw_sync_q;
      sw_cnt_n  = '0;
    end else if (sw_cnt_q == SW_CNT_MAX) begin
      sw_db_n = sw_cand_q;
    end else begin
      sw_cnt_n = sw_cnt_q + SW_CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_cand_q <= '0;
      sw_cnt_q  <= '0;
      SW_db     <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      sw_cand_q <= sw_cand_n;
      sw_cnt_q  <= sw_cnt_n;
      SW_db     <= sw_db_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiple-switch guard
  // ---------------------------------------------------------------------------
  logic sel_block_c;

`ifdef ONEHOT_GUARD_EN
  logic [3:0] sw_pop_c;
  logic       sw_error_n;
  logic       sw_error_q;

  // Zero or one switch up is legal; two or more block the select keys.
  always_comb begin
    sw_pop_c = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      sw_pop_c = sw_pop_c + 4'(SW_db[i]);
    end
    sw_error_n = (sw_pop_c >= 4'd2);
  end

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      sw_error_q <= 1'b0;
    end else begin
      sw_error_q <= sw_error_n;
    end
  end

  assign sw_error    = sw_error_q;
  assign sel_block_c = sw_error_q;
`else
  assign sw_error    = 1'b0;
  assign sel_block_c = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Session FSM and event arbitration
  // ---------------------------------------------------------------------------
  session_e state_q;
  session_e state_n;
  logic     go_prev_q;
  logic     go_rise_c;
  logic     quit_ev_c;
  logic     start_ev_c;
  logic     sel1_ev_c;
  logic     sel2_ev_c;
  logic     select1_n;
  logic     select2_n;
  logic     userquit_n;

  assign go_rise_c  = gameOver & ~go_prev_q;
  assign quit_ev_c  = key_fall_c[KEY_QUIT];
  assign start_ev_c = key_fall_c[KEY_START];
  assign sel1_ev_c  = key_fall_c[KEY_SEL1];
  assign sel2_ev_c  = key_fall_c[KEY_SEL2];

  // Priority: quit over everything, gameOver edge over start, select1 over select2.
  // userquit is not gated by the session; selects need an active session.
  always_comb begin
    state_n    = state_q;
    select1_n  = 1'b0;
    select2_n  = 1'b0;
    userquit_n = quit_ev_c;
    case (state_q)
      ST_IDLE: begin
        if (start_ev_c && !go_rise_c && !quit_ev_c) begin
          state_n = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (quit_ev_c || go_rise_c) begin
          state_n = ST_IDLE;
        end
        if (!quit_ev_c && !sel_block_c) begin
          select1_n = sel1_ev_c;
          select2_n = sel2_ev_c & ~sel1_ev_c;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      go_prev_q <= 1'b0;
      select1   <= 1'b0;
      select2   <= 1'b0;
      userquit  <= 1'b0;
    end else begin
      state_q   <= state_n;
      go_prev_q <= gameOver;
      select1   <= select1_n;
      select2   <= select2_n;
      userquit  <= userquit_n;
    end
  end

  assign inGameOn = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_tile_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tile_input_ctrl
//
// Directed bench for tile_input_ctrl with both debounce lengths set to 4.
// Inputs change 1 time unit after a rising edge. Outputs are checked 1 time
// unit after the edge that should have produced them. A negedge monitor counts
// output pulses and flags any cycle with more than one pulse high.
// -----------------------------------------------------------------------------
module tb_tile_input_ctrl;

  localparam int unsigned DB   = 4;
  localparam int unsigned SWDB = 4;

`ifdef ONEHOT_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic       CLOCK_50;
  logic       clear;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic       gameOver;
  logic       select1;
  logic       select2;
  logic       userquit;
  logic       inGameOn;
  logic [9:0] SW_db;
  logic       sw_error;

  int checks   = 0;
  int failures = 0;
  int n_sel1   = 0;
  int n_sel2   = 0;
  int n_quit   = 0;
  int n_multi  = 0;
  int exp_sel2 = 0;

  tile_input_ctrl #(
    .DEBOUNCE_CYCLES    (DB),
    .SW_DEBOUNCE_CYCLES (SWDB)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .clear    (clear),
    .KEY      (KEY),
    .SW       (SW),
    .gameOver (gameOver),
    .select1  (select1),
    .select2  (select2),
    .userquit (userquit),
    .inGameOn (inGameOn),
    .SW_db    (SW_db),
    .sw_error (sw_error)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Pulse counters and at-most-one-pulse monitor.
  always @(negedge CLOCK_50) begin
    if (clear) begin
      n_sel1 = n_sel1 + int'(select1);
      n_sel2 = n_sel2 + int'(select2);
      n_quit = n_quit + int'(userquit);
      if (int'(select1) + int'(select2) + int'(userquit) > 1) n_multi = n_multi + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear    = 1'b0;
    KEY      = 4'hF;
    SW       = 10'h000;
    gameOver = 1'b0;
    step(3);

    // Reset state
    check("rst_inGameOn", 32'(inGameOn), 32'd0);
    check("rst_select1",  32'(select1),  32'd0);
    check("rst_select2",  32'(select2),  32'd0);
    check("rst_userquit", 32'(userquit), 32'd0);
    check("rst_SW_db",    32'(SW_db),    32'd0);
    check("rst_sw_error", 32'(sw_error), 32'd0);
    clear = 1'b1;
    step(2);

    // Start press: session on exactly 7 edges after the key goes low
    KEY[3] = 1'b0;
    step(6);
    check("start_early", 32'(inGameOn), 32'd0);
    step(1);
    check("start_on", 32'(inGameOn), 32'd1);
    KEY[3] = 1'b1;
    step(10);
    check("start_release", 32'(inGameOn), 32'd1);

    // select1 press: single pulse at E+7, nothing more while held
    KEY[1] = 1'b0;
    step(6);
    check("sel1_early", 32'(select1), 32'd0);
    step(1);
    check("sel1_pulse", 32'(select1), 32'd1);
    check("sel1_no_sel2", 32'(select2), 32'd0);
    step(1);
    check("sel1_one_cycle", 32'(select1), 32'd0);
    step(10);
    check("sel1_held_count", 32'(n_sel1), 32'd1);
    KEY[1] = 1'b1;
    step(10);
    check("sel1_release_count", 32'(n_sel1), 32'd1);

    // Glitch of 3 cycles is rejected, then a real press still has full latency
    KEY[2] = 1'b0;
    step(3);
    KEY[2] = 1'b1;
    step(12);
    check("glitch_sel2", 32'(n_sel2), 32'd0);
    KEY[2] = 1'b0;
    step(6);
    check("sel2_early", 32'(select2), 32'd0);
    step(1);
    check("sel2_pulse", 32'(select2), 32'd1);
    KEY[2] = 1'b1;
    step(10);
    exp_sel2 = 1;
    check("sel2_count", 32'(n_sel2), 32'(exp_sel2));

    // Quit and select1 together: quit wins, session ends in the pulse cycle
    KEY[0] = 1'b0;
    KEY[1] = 1'b0;
    step(7);
    check("quit_pulse", 32'(userquit), 32'd1);
    check("quit_sel1_drop", 32'(select1), 32'd0);
    check("quit_session_off", 32'(inGameOn), 32'd0);
    step(1);
    check("quit_one_cycle", 32'(userquit), 32'd0);
    KEY = 4'hF;
    step(10);
    check("quit_count", 32'(n_quit), 32'd1);
    check("quit_sel1_count", 32'(n_sel1), 32'd1);

    // gameOver rising edge ends session; start still works with gameOver held
    KEY[3] = 1'b0;
    step(7);
    check("restart_on", 32'(inGameOn), 32'd1);
    KEY[3] = 1'b1;
    step(10);
    gameOver = 1'b1;
    check("go_before_edge", 32'(inGameOn), 32'd1);
    step(1);
    check("go_session_off", 32'(inGameOn), 32'd0);
    KEY[1] = 1'b0;
    step(10);
    check("go_sel1_dropped", 32'(n_sel1), 32'd1);
    KEY[1] = 1'b1;
    step(10);
    check("go_sel1_dropped_later", 32'(n_sel1), 32'd1);
    KEY[3] = 1'b0;
    step(7);
    check("go_high_start", 32'(inGameOn), 32'd1);
    KEY[3] = 1'b1;
    step(10);
    gameOver = 1'b0;
    step(2);
    check("go_fall_no_effect", 32'(inGameOn), 32'd1);

    // Switch bounce: SW_db holds 0 until the vector stays put long enough
    for (int i = 0; i < 4; i++) begin
      SW = (i % 2 == 0) ? 10'h004 : 10'h000;
      step(2);
      check("sw_bounce_hold", 32'(SW_db), 32'h000);
    end
    SW = 10'h004;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("sw_no_intermediate", 32'((SW_db == 10'h000) || (SW_db == 10'h004)), 32'd1);
      if (k == 5) check("sw_still_old", 32'(SW_db), 32'h000);
      if (k == 8) check("sw_new_value", 32'(SW_db), 32'h004);
    end

    // Two switches up: guard blocks select2 only when enabled
    SW = 10'h005;
    step(10);
    check("sw_two_up", 32'(SW_db), 32'h005);
    check("sw_error_two_up", 32'(sw_error), 32'(GUARD));
    KEY[2] = 1'b0;
    step(7);
    check("guard_sel2", 32'(select2), 32'(!GUARD));
    KEY[2] = 1'b1;
    step(10);
    if (!GUARD) exp_sel2 = exp_sel2 + 1;
    check("guard_sel2_count", 32'(n_sel2), 32'(exp_sel2));

    SW = 10'h004;
    step(10);
    check("sw_one_up", 32'(SW_db), 32'h004);
    check("sw_error_one_up", 32'(sw_error), 32'd0);
    KEY[2] = 1'b0;
    step(7);
    check("unguard_sel2", 32'(select2), 32'd1);
    KEY[2] = 1'b1;
    step(10);
    exp_sel2 = exp_sel2 + 1;
    check("unguard_sel2_count", 32'(n_sel2), 32'(exp_sel2));

    // select1 and select2 together: select1 wins
    KEY[1] = 1'b0;
    KEY[2] = 1'b0;
    step(7);
    check("both_sel1", 32'(select1), 32'd1);
    check("both_sel2_drop", 32'(select2), 32'd0);
    KEY = 4'hF;
    step(10);
    check("both_sel2_count", 32'(n_sel2), 32'(exp_sel2));

    // Reset mid-debounce: in-progress quit press is lost
    KEY[0] = 1'b0;
    step(3);
    clear  = 1'b0;
    KEY[0] = 1'b1;
    step(2);
    check("midrst_session", 32'(inGameOn), 32'd0);
    check("midrst_SW_db", 32'(SW_db), 32'h000);
    clear = 1'b1;
    step(15);
    check("midrst_no_quit", 32'(n_quit), 32'd1);
    check("midrst_session_idle", 32'(inGameOn), 32'd0);

    check("one_pulse_per_cycle", 32'(n_multi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_input_ctrl.md
Name: tile_input_ctrl

Overview:
Front-end for the tile-matching game, on the producing side of the in-game FSM's control inputs. It synchronises and debounces raw DE1 pushbuttons and slide switches. From them it generates single-cycle select1, select2 and userquit pulses, the level inGameOn, and debounced SW. It sits between the board pins and the in-game FSM, and consumes the FSM's gameOver flag to end a session.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a key changes state (20 ms at 50 MHz)
SW_DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before the switch vector is accepted

Ports:
CLOCK_50  input  1  system clock
clear  input  1  asynchronous active-low reset
KEY  input  4  raw pushbuttons, active-low; [0]=quit, [1]=select1, [2]=select2, [3]=start
SW  input  10  raw slide switches
gameOver  input  1  from in-game FSM, level
select1  output  1  one-cycle pulse
select2  output  1  one-cycle pulse
userquit  output  1  one-cycle pulse
inGameOn  output  1  level, session active
SW_db  output  10  debounced switches
sw_error  output  1  more than one debounced switch up (see optional feature)

Behaviour:
- Reset (clear=0, async): sync flops and stable key states = 1 (released); counters = 0; SW_db = 0; select1, select2, userquit, inGameOn and sw_error = 0.
- Sync: each KEY bit and SW bit passes through a 2-flop synchroniser.
- Key debounce, per key:
  - Counter clears whenever the synced value equals the stable value.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the stable value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES leaves the stable value unchanged.
- Press event: stable transition 1->0, one cycle wide. Release generates nothing.
- Latency: a KEY held low from edge E produces its pulse on rising edge E+DEBOUNCE_CYCLES+3 (2 sync + debounce + output register). The pulse is exactly 1 cycle and never repeats while the key stays held.
- Switch debounce:
  - One shared counter compares the synced SW vector with a 10-bit candidate register.
  - On mismatch: candidate <= synced SW, counter clears.
  - On match: counter increments. When it reaches SW_DEBOUNCE_CYCLES-1, SW_db <= candidate.
  - SW_db updates only as a whole vector, never per bit.
- Session state (inGameOn):
  - Start press while inGameOn=0: set to 1.
  - Start press while inGameOn=1: ignored.
  - Quit press: clears to 0 and emits userquit. userquit is emitted regardless of inGameOn.
  - gameOver rising edge (registered previous value): clears to 0. A level-high gameOver does not block a later start press.
- Pulse gating: select1 and select2 are emitted only while inGameOn=1. Presses while inactive are dropped, not queued.
- Simultaneous events in one cycle:
  - Quit beats start: inGameOn ends 0.
  - Quit beats both selects: selects dropped.
  - select1 beats select2: select2 dropped.
  - gameOver rising edge beats start: inGameOn ends 0.
- At most one of select1, select2 and userquit is high in any cycle.
- Reset mid-debounce: counters clear and the in-progress press is lost; no pulse is emitted after reset deasserts.

Optional Feature:
ONEHOT_GUARD_EN
- Defined: sw_error = 1 while popcount(SW_db) >= 2, registered, so it follows SW_db by 1 cycle. While sw_error=1, select1 and select2 presses are dropped, not queued. userquit and start are unaffected. Zero switches up is legal, so select1 stays usable as the confirm key.
- Undefined: sw_error tied 0 and selects are never gated by SW.

Test Plan:
Use DEBOUNCE_CYCLES=4 and SW_DEBOUNCE_CYCLES=4 throughout.
1. Reset, start press: KEY[3] low from edge 10 -> inGameOn=1 at edge 17. KEY[1] low from edge 30 -> select1=1 only at edge 37, held key gives no further pulse.
2. Glitch rejection: KEY[2] low for 3 cycles then high -> no select2 pulse, stable state unchanged.
3. Quit priority: KEY[0] and KEY[1] low same cycle with inGameOn=1 -> userquit single pulse, select1 never asserts, inGameOn=0 in the pulse cycle.
4. Session end: inGameOn=1, gameOver 0->1 -> inGameOn=0 next cycle. KEY[1] press -> no select1. KEY[3] press with gameOver still 1 -> inGameOn=1.
5. Switch debounce: SW 0x000->0x004, bouncing every 2 cycles for 10 cycles then stable -> SW_db stays 0x000 during the bounce, becomes 0x004 after 4+2 stable cycles, no intermediate value.
6. ONEHOT_GUARD_EN defined: SW_db=0x005, KEY[2] press -> sw_error=1, no select2. SW_db->0x004, KEY[2] press -> select2 pulse, sw_error=0.
